countdown_timer_ctrl: RTL and testbench
=======================================

// Module: countdown_timer_ctrl
// PURPOSE
//  Sequencer for a chain of NUM_DIGITS BCD down-counting digits. Together they form a
//  presettable countdown timer: load preset, run, pause/resume, abort, detect expiry.
//  Sits between the user-control logic (buttons, debounced to 1-cycle pulses) and the
//  display decoders. It owns the prescaler, the digit chain and the run/pause FSM.
// PARAMETERS
//  NUM_DIGITS  4         number of BCD digits; digit 0 is least significant
//  TICK_DIV    50000000  clk cycles per count step (>=2)
//  CNT_W       26        prescaler width; must satisfy 2**CNT_W >= TICK_DIV
// PORTS
//  clk         in   1             clock, rising edge
//  rst         in   1             asynchronous, active-high reset
//  start       in   1             1-cycle pulse: load preset and run
//  pause_tgl   in   1             1-cycle pulse: toggle RUN<->PAUSED
//  abort       in   1             1-cycle pulse: return to IDLE, digits cleared
//  preset      in   4*NUM_DIGITS  BCD preset, digit k at [4k+3:4k]
//  digits      out  4*NUM_DIGITS  current BCD count
//  running     out  1             1 in RUN
//  paused      out  1             1 in PAUSED
//  done        out  1             1 in DONE (level)
//  done_pulse  out  1             1-cycle pulse on entry to DONE
// BEHAVIOUR
//  - Reset: state=IDLE, digits=0, prescaler=0, all flag outputs 0. All outputs registered.
//  - States: IDLE, LOAD, RUN, PAUSED, DONE (shared enum).
//  - Input priority per cycle: abort > start > pause_tgl.
//  - abort in any state: next state IDLE, digits<=0, prescaler<=0.
//  - start in IDLE or DONE: go to LOAD. start in LOAD/RUN/PAUSED: ignored.
//  - LOAD (1 cycle): digits<=preset; any preset digit >9 is clamped to 9; prescaler<=0.
//    Next state: RUN if the clamped value is nonzero, else DONE with done_pulse.
//  - RUN: prescaler increments each cycle. At TICK_DIV-1 it wraps to 0 and issues a tick.
//    First tick comes TICK_DIV cycles after entering RUN.
//  - On tick, digit 0 decrements. Digit k decrements iff all lower digits are 0
//    (borrow chain). A digit at 0 that decrements wraps to 9.
//  - Tick whose result is all-zero: the next state is DONE. digits reads 0 on the same
//    edge that done and done_pulse rise. No further decrement occurs; no wrap to 99..9.
//  - pause_tgl in RUN: go to PAUSED; prescaler and digits freeze.
//    pause_tgl in PAUSED: go to RUN; prescaler resumes from its frozen value.
//    pause_tgl in IDLE, LOAD or DONE: ignored.
//  - A tick and a pause_tgl in the same cycle: the tick is applied, then the FSM pauses.
//  - DONE: digits hold 0 and done=1 until start (reload) or abort.
//  - rst mid-run: immediate asynchronous return to the reset values above.
// STRUCTURE
//  - Package timer_pkg: state enum (IDLE/LOAD/RUN/PAUSED/DONE), BCD_MAX=4'd9,
//    and a function clamp_bcd(4b)->4b.
//  - Sub-module bcd_down_digit, instantiated NUM_DIGITS times (generate).
//    Inputs: clk, rst, load, din, dec. Outputs: q, is_zero.
//  - Top level holds the FSM, prescaler, borrow-chain enables (AND of lower is_zero)
//    and the all-zero detect.
// TESTING (TICK_DIV=4, NUM_DIGITS=2)
//  1 preset=8'h12, start -> LOAD then RUN; digits 12,11,10,09,...,01,00 every 4 cycles;
//    done_pulse exactly once when digits reach 00; done stays 1.
//  2 preset=8'h10 -> digits 10 then 09: digit1 borrow, digit0 wraps 0->9.
//  3 preset=8'h00, start -> DONE directly after LOAD; done_pulse=1; running never 1.
//  4 preset=8'h05, run 2 cycles, pause_tgl, hold 20 cycles -> digits frozen at 05;
//    pause_tgl -> next tick after 2 more cycles.
//  5 preset=8'hAF -> clamped to 99. abort mid-RUN -> IDLE, digits=00, flags 0.
//    start+abort in same cycle -> IDLE.
//  6 rst asserted mid-RUN, between clock edges -> digits=00, state IDLE immediately;
//    start after release -> normal run.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and helpers for the BCD countdown timer.
// Holds the sequencer state enum, the BCD limit and the preset clamp.
package timer_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RUN    = 3'd2,
    PAUSED = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Non-BCD nibbles (A..F) saturate to 9.
  function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit: synchronous load, decrement with 0->9 wrap.
// Ports: clk, rst (async high), load, din[3:0], dec -> q[3:0], is_zero.
module bcd_down_digit
  import timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] din,
  input  logic       dec,
  output logic [3:0] q,
  output logic       is_zero
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 4'd0;
    end else if (load) begin
      q <= din;
    end else if (dec) begin
      q <= (q == 4'd0) ? BCD_MAX : q - 4'd1;
    end
  end

  assign is_zero = (q == 4'd0);

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Presettable BCD countdown timer: prescaler, digit chain, run/pause FSM.
// Ports: clk, rst, start, pause_tgl, abort, preset -> digits, running,
//        paused, done, done_pulse (all outputs registered).
module countdown_timer_ctrl
  import timer_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 50000000,
  parameter int CNT_W      = 26
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    pause_tgl,
  input  logic                    abort,
  input  logic [4*NUM_DIGITS-1:0] preset,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    running,
  output logic                    paused,
  output logic                    done,
  output logic                    done_pulse
);

  state_t state;
  state_t state_nx;

  logic [CNT_W-1:0]        pre;
  logic                    tick;
  logic [4*NUM_DIGITS-1:0] pre_cl;
  logic                    preset_zero;
  logic [NUM_DIGITS-1:0]   zero;
  logic [NUM_DIGITS-1:0]   dec;
  logic                    hi_zero;
  logic                    last_tick;
  logic                    ld;

  assign tick = (state == RUN) && (pre == CNT_W'(TICK_DIV - 1));
  assign ld   = abort || (state == LOAD);

  // Abort reuses the load path with an all-zero value.
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
    assign pre_cl[4*k +: 4] = clamp_bcd(preset[4*k +: 4]);
    bcd_down_digit u_dig (
      .clk     (clk),
      .rst     (rst),
      .load    (ld),
      .din     (abort ? 4'd0 : pre_cl[4*k +: 4]),
      .dec     (dec[k]),
      .q       (digits[4*k +: 4]),
      .is_zero (zero[k])
    );
  end

  assign preset_zero = (pre_cl == '0);

  // Borrow chain: digit k steps only when every lower digit is 0.
  always_comb begin
    dec     = '0;
    hi_zero = 1'b1;
    dec[0]  = tick;
    for (int k = 1; k < NUM_DIGITS; k++) begin
      dec[k]  = dec[k-1] & zero[k-1];
      hi_zero = hi_zero & zero[k];
    end
  end

  // This tick takes the count from 1 to 0: stop instead of wrapping.
  assign last_tick = tick && (digits[3:0] == 4'd1) && hi_zero;

  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE, DONE: if (start) state_nx = LOAD;
        LOAD:       state_nx = preset_zero ? DONE : RUN;
        RUN: begin
          if (last_tick)      state_nx = DONE;
          else if (pause_tgl) state_nx = PAUSED;
        end
        PAUSED:     if (pause_tgl) state_nx = RUN;
        default:    state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre <= '0;
    end else if (ld) begin
      pre <= '0;
    end else if (state == RUN) begin
      pre <= tick ? '0 : pre + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running    <= 1'b0;
      paused     <= 1'b0;
      done       <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      running    <= (state_nx == RUN);
      paused     <= (state_nx == PAUSED);
      done       <= (state_nx == DONE);
      done_pulse <= (state_nx == DONE) && (state != DONE);
    end
  end

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Scoreboard bench for countdown_timer_ctrl (NUM_DIGITS=2, TICK_DIV=4).
// Expected output changes are queued with their edge number and popped by a monitor.
module tb_countdown_timer_ctrl;

  typedef struct packed {
    logic [7:0] d;
    logic       r;
    logic       p;
    logic       dn;
    logic       dp;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t o;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       pause_tgl = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] preset = 8'h00;
  logic [7:0] digits;
  logic       running, paused, done, done_pulse;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  ev_t  sb[$];
  obs_t last_exp = '0;

  countdown_timer_ctrl #(
    .NUM_DIGITS (2),
    .TICK_DIV   (4),
    .CNT_W      (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pause_tgl  (pause_tgl),
    .abort      (abort),
    .preset     (preset),
    .digits     (digits),
    .running    (running),
    .paused     (paused),
    .done       (done),
    .done_pulse (done_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  function automatic obs_t now_obs();
    return obs_t'({digits, running, paused, done, done_pulse});
  endfunction

  task automatic exp(input int c, input logic [7:0] d,
                     input logic r, input logic p,
                     input logic dn, input logic dp);
    obs_t o;
    ev_t  ev;
    o = obs_t'({d, r, p, dn, dp});
    if (o != last_exp) begin
      ev.cyc = c;
      ev.o   = o;
      sb.push_back(ev);
      last_exp = o;
    end
  endtask

  task automatic count_from(input int t0, input int v);
    for (int k = 0; k <= v; k++) begin
      if (v - k > 0) begin
        exp(t0 + 4*k, bcd(v - k), 1, 0, 0, 0);
      end else begin
        exp(t0 + 4*k, 8'h00, 0, 0, 1, 1);
        exp(t0 + 4*k + 1, 8'h00, 0, 0, 1, 0);
      end
    end
  endtask

  // Sets inputs so they are sampled at edge 'want' (or the next one).
  task automatic drive(input int want, input logic s, input logic pt,
                       input logic ab, output int e);
    @(negedge clk);
    while (cyc + 1 < want) @(negedge clk);
    start     = s;
    pause_tgl = pt;
    abort     = ab;
    e         = cyc + 1;
  endtask

  task automatic rel();
    @(negedge clk);
    start     = 1'b0;
    pause_tgl = 1'b0;
    abort     = 1'b0;
  endtask

  task automatic chk(input string n, input logic [11:0] got,
                     input logic [11:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", n, got, want, cyc);
    end
  endtask

  task automatic drain(input string n);
    int w;
    w = 0;
    while (sb.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d events pending, expected 0", n, sb.size());
      sb.delete();
    end
  endtask

  // Monitor: every observable change must match the next queued event.
  initial begin
    obs_t prev;
    obs_t cur;
    ev_t  ev;
    prev = '0;
    forever begin
      @(negedge clk);
      cur = now_obs();
      if (cur !== prev) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change: got %h at cyc %0d, expected none",
                   cur, cyc);
        end else begin
          ev = sb.pop_front();
          if (ev.o !== cur || ev.cyc != cyc) begin
            errors++;
            $display("FAIL event: got %h at cyc %0d expected %h at cyc %0d",
                     cur, cyc, ev.o, ev.cyc);
          end
        end
        prev = cur;
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: sim time limit hit, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int s, p, r, a, b;
    repeat (2) @(negedge clk);
    chk("reset", now_obs(), 12'h000);
    rst = 1'b0;

    // 1: 12 down to 00
    preset = 8'h12;
    drive(0, 1, 0, 0, s);
    count_from(s + 1, 12);
    rel();
    drain("t1");

    // 2: borrow 10 -> 09, from DONE
    preset = 8'h10;
    drive(0, 1, 0, 0, s);
    exp(s, 8'h00, 0, 0, 0, 0);
    count_from(s + 1, 10);
    rel();
    drain("t2");

    // 3: zero preset goes straight to DONE
    preset = 8'h00;
    drive(0, 1, 0, 0, s);
    exp(s, 8'h00, 0, 0, 0, 0);
    exp(s + 1, 8'h00, 0, 0, 1, 1);
    exp(s + 2, 8'h00, 0, 0, 1, 0);
    rel();
    drain("t3");

    // 4: pause/resume
    preset = 8'h05;
    drive(0, 1, 0, 0, s);
    exp(s, 8'h00, 0, 0, 0, 0);
    exp(s + 1, 8'h05, 1, 0, 0, 0);
    rel();
    drive(s + 3, 0, 1, 0, p);
    exp(p, 8'h05, 0, 1, 0, 0);
    rel();
    repeat (10) @(negedge clk);
    chk("pause_hold", now_obs(), {8'h05, 4'b0100});
    drive(p + 20, 0, 1, 0, r);
    exp(r, 8'h05, 1, 0, 0, 0);
    count_from(r + 2, 4);
    rel();
    drain("t4");

    // 5a: clamp AF -> 99, abort mid-RUN
    preset = 8'hAF;
    drive(0, 1, 0, 0, s);
    exp(s, 8'h00, 0, 0, 0, 0);
    exp(s + 1, 8'h99, 1, 0, 0, 0);
    exp(s + 5, 8'h98, 1, 0, 0, 0);
    rel();
    drive(s + 7, 0, 0, 1, a);
    exp(a, 8'h00, 0, 0, 0, 0);
    rel();
    drain("t5a");

    // 5b: tick and pause on the same edge, then abort from PAUSED
    preset = 8'h21;
    drive(0, 1, 0, 0, s);
    exp(s + 1, 8'h21, 1, 0, 0, 0);
    rel();
    drive(s + 5, 0, 1, 0, p);
    exp(p, 8'h20, 0, 1, 0, 0);
    rel();
    drive(p + 4, 0, 0, 1, a);
    exp(a, 8'h00, 0, 0, 0, 0);
    rel();
    drive(0, 1, 0, 1, b);
    rel();
    repeat (6) @(negedge clk);
    chk("start_abort_idle", now_obs(), 12'h000);
    drain("t5b");

    // 6: async reset mid-RUN, then a normal run
    preset = 8'h12;
    drive(0, 1, 0, 0, s);
    exp(s + 1, 8'h12, 1, 0, 0, 0);
    exp(s + 5, 8'h11, 1, 0, 0, 0);
    rel();
    while (cyc < s + 5) @(negedge clk);
    @(posedge clk);
    #2;
    exp(s + 6, 8'h00, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("rst_async", now_obs(), 12'h000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    preset = 8'h03;
    drive(0, 1, 0, 0, s);
    count_from(s + 1, 3);
    rel();
    drain("t6");

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
